apu_decimation_filter: RTL and testbench

Polyphase 64-tap FIR decimator for the APU audio-input path. It accepts one signed 16-bit sample per `en` strobe at the 768 kHz oversampled rate (16 × 48 kHz) and emits one filtered, 16:1 decimated 48 kHz sample with a single-cycle valid pulse. It is the receive-side counterpart of the APU interpolating lowpass filter and uses the same 22 kHz coefficient table. Four staggered accumulators replace a 64-entry delay line.

---
 rtl/apu_filter_pkg.sv | 20 ++
 rtl/apu_decim_mac.sv | 41 ++++
 rtl/apu_decimation_filter.sv | 77 +++++++
 tb/tb_apu_decimation_filter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/apu_filter_pkg.sv
// Shared constants and the 64-tap 22 kHz lowpass table used by the APU
// interpolator and decimation filters.
package apu_filter_pkg;
  localparam int W_SAMPLE = 16;
  localparam int W_COEFF  = 9;
  localparam int TAPS     = 64;
  localparam int PHASES   = 16;

  // DC sum 3560, magnitude sum 3892.
  localparam logic signed [W_COEFF-1:0] COEFF [TAPS] = '{
    -9'sd2,   -9'sd3,   -9'sd4,   -9'sd5,   -9'sd6,   -9'sd7,   -9'sd10,  -9'sd10,
    -9'sd10,  -9'sd7,   -9'sd6,   -9'sd4,   -9'sd2,   9'sd0,    9'sd3,    9'sd9,
    9'sd18,   9'sd28,   9'sd40,   9'sd54,   9'sd69,   9'sd85,   9'sd102,  9'sd119,
    9'sd135,  9'sd150,  9'sd164,  9'sd176,  9'sd187,  9'sd195,  9'sd201,  9'sd204,
    9'sd202,  9'sd190,  9'sd182,  9'sd170,  9'sd158,  9'sd146,  9'sd132,  9'sd118,
    9'sd110,  9'sd101,  9'sd84,   9'sd67,   9'sd51,   9'sd37,   9'sd24,   9'sd12,
    9'sd3,    -9'sd3,   -9'sd7,   -9'sd9,   -9'sd13,  -9'sd13,  -9'sd9,   -9'sd8,
    -9'sd7,   -9'sd6,   -9'sd5,   -9'sd4,   -9'sd3,   -9'sd2,   -9'sd1,   9'sd0
  };
endpackage

// File: rtl/apu_decim_mac.sv
// One staggered accumulator slot of the polyphase decimator; its age
// m = SLOT - r selects which quarter of the coefficient table it applies.
module apu_decim_mac
  import apu_filter_pkg::*;
#(
  parameter int         W_ACC = 32,
  parameter logic [1:0] SLOT  = 2'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic [3:0]                 p,
  input  logic [1:0]                 r,
  input  logic signed [W_SAMPLE-1:0] d,
  output logic signed [W_ACC-1:0]    acc_next
);
  localparam int W_PROD = W_SAMPLE + W_COEFF;

  logic [1:0]               m;
  logic signed [W_PROD-1:0] dx, cx, prod;
  logic signed [W_ACC-1:0]  acc;
  logic                     last;

  always_comb begin
    m        = SLOT - r;
    dx       = {{W_COEFF{d[W_SAMPLE-1]}}, d};
    cx       = {{W_SAMPLE{COEFF[{m, p}][W_COEFF-1]}}, COEFF[{m, p}]};
    prod     = dx * cx;
    acc_next = acc + {{(W_ACC-W_PROD){prod[W_PROD-1]}}, prod};
    last     = (m == 2'd3) && (p == 4'hF);
  end

  // The completing slot restarts empty; its final sum leaves via acc_next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  acc <= '0;
    else if (clr)             acc <= '0;
    else if (en && last)      acc <= '0;
    else if (en)              acc <= acc_next;
  end
endmodule

// File: rtl/apu_decimation_filter.sv
// 64-tap 16:1 polyphase FIR decimator built from four staggered MAC slots.
// Define APU_DECIM_ROUND_EN for round-half-up output instead of floor.
module apu_decimation_filter
  import apu_filter_pkg::*;
#(
  parameter int W_ACC = 32,
  parameter int SHIFT = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [W_SAMPLE-1:0] d,
  input  logic                       flush,
  output logic signed [W_SAMPLE-1:0] q,
  output logic                       q_valid
);
  localparam int SLOTS = TAPS / PHASES;

  logic [3:0]              p;
  logic [1:0]              r, blank, done_slot;
  logic signed [W_ACC-1:0] acc_next [SLOTS];
  logic signed [W_ACC-1:0] acc_done, acc_rnd;
  logic signed [W_SAMPLE-1:0] q_nxt;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_mac
    apu_decim_mac #(.W_ACC(W_ACC), .SLOT(2'(gi))) u_mac (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (flush),
      .p        (p),
      .r        (r),
      .d        (d),
      .acc_next (acc_next[gi])
    );
  end

  always_comb begin
    done_slot = r + 2'd3;
    acc_done  = acc_next[done_slot];
`ifdef APU_DECIM_ROUND_EN
    acc_rnd   = acc_done + (W_ACC'(1) <<< (SHIFT - 1));
`else
    acc_rnd   = acc_done;
`endif
    q_nxt     = W_SAMPLE'(acc_rnd >>> SHIFT);
  end

  // Flush restarts the frame but keeps the last published sample on q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      r       <= '0;
      blank   <= 2'd3;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      if (flush) begin
        p     <= '0;
        r     <= '0;
        blank <= 2'd3;
      end else if (en) begin
        p <= p + 4'd1;
        if (p == 4'hF) begin
          r <= r - 2'd1;
          if (blank == 2'd0) begin
            q       <= q_nxt;
            q_valid <= 1'b1;
          end else begin
            blank <= blank - 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_apu_decimation_filter.sv
// Directed bench for apu_decimation_filter: warm-up, impulse, full scale,
// rounding, irregular strobes, flush and asynchronous reset.
module tb_apu_decimation_filter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] d = '0;
  logic [15:0] q;
  logic        q_valid;

  int checks = 0;
  int errors = 0;
  int npulse;

  apu_decimation_filter dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .d       (d),
    .flush   (flush),
    .q       (q),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input logic en_v, input logic [15:0] d_v, input logic fl_v);
    @(negedge clk);
    en = en_v; d = d_v; flush = fl_v;
    @(posedge clk);
    #1;
    en = 1'b0; flush = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] v, input int n);
    npulse = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, v, 1'b0);
      if (q_valid) npulse++;
    end
  endtask

  logic [15:0] imp_exp [5];
  logic [15:0] rnd_exp;

  initial begin
    imp_exp = '{16'h0003, 16'h00CA, 16'h0012, 16'hFFFE, 16'h0000};
`ifdef APU_DECIM_ROUND_EN
    rnd_exp = 16'h0001;
`else
    rnd_exp = 16'h0000;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_q", q, 16'h0000);
    chk("reset_q_valid", q_valid, 0);
    rst = 1'b0;

    // DC warm-up: 63 strobes silent, 64th publishes
    send_n(16'h1000, 63);
    chk("warmup_no_valid", npulse, 0);
    step(1'b1, 16'h1000, 1'b0);
    chk("warmup_first_valid", q_valid, 1);
    chk("warmup_first_q", q, 16'h0DE8);
    step(1'b0, 16'h0000, 1'b0);
    chk("valid_one_cycle", q_valid, 0);
    chk("q_held_idle", q, 16'h0DE8);
    send_n(16'h1000, 15);
    chk("dc_midframe_no_valid", npulse, 0);
    step(1'b1, 16'h1000, 1'b0);
    chk("dc_second_valid", q_valid, 1);
    chk("dc_second_q", q, 16'h0DE8);

    // Impulse: drain history with three zero frames, then one impulse
    send_n(16'h0000, 48);
    for (int f = 0; f < 5; f++) begin
      step(1'b1, (f == 0) ? 16'h1000 : 16'h0000, 1'b0);
      send_n(16'h0000, 14);
      chk("impulse_mid_no_valid", npulse, 0);
      step(1'b1, 16'h0000, 1'b0);
      chk("impulse_valid", q_valid, 1);
      chk($sformatf("impulse_q%0d", f), q, imp_exp[f]);
    end

    // Full-scale DC both polarities
    send_n(16'h7FFF, 63);
    chk("fs_pos_pulses", npulse, 3);
    step(1'b1, 16'h7FFF, 1'b0);
    chk("fs_pos_valid", q_valid, 1);
    chk("fs_pos_q", q, 16'h6F3F);
    send_n(16'h8000, 64);
    chk("fs_neg_valid", q_valid, 1);
    chk("fs_neg_q", q, 16'h90C0);

    // Rounding of a tiny DC input
    send_n(16'h0001, 64);
    chk("round_valid", q_valid, 1);
    chk("round_q", q, rnd_exp);

    // Irregular strobes with 0..5 idle cycles between them
    npulse = 0;
    for (int i = 1; i <= 96; i++) begin
      int gaps;
      gaps = $urandom_range(0, 5);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 16'h0000, 1'b0);
        if (q_valid) npulse++;
      end
      step(1'b1, 16'h1000, 1'b0);
      chk("irr_valid_on_16th", q_valid, (i % 16 == 0) ? 1 : 0);
      if (i >= 64 && i % 16 == 0) chk("irr_q", q, 16'h0DE8);
    end
    chk("irr_no_idle_pulses", npulse, 0);

    // Flush together with en mid-frame: sample dropped, q held, restart
    send_n(16'h1000, 5);
    step(1'b1, 16'h7FFF, 1'b1);
    chk("flush_valid_low", q_valid, 0);
    chk("flush_q_held", q, 16'h0DE8);
    send_n(16'h1000, 63);
    chk("flush_warmup_no_valid", npulse, 0);
    step(1'b1, 16'h1000, 1'b0);
    chk("flush_first_valid", q_valid, 1);
    chk("flush_first_q", q, 16'h0DE8);

    // Asynchronous reset mid-frame
    send_n(16'h7FFF, 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 16'h0000);
    chk("async_rst_valid", q_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    send_n(16'h1000, 63);
    chk("rst_warmup_no_valid", npulse, 0);
    step(1'b1, 16'h1000, 1'b0);
    chk("rst_first_valid", q_valid, 1);
    chk("rst_first_q", q, 16'h0DE8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
